// File: rtl/ccdiv_pkg.sv
// Shared fixed-point parameters and result helpers for the ccdiv complex divider.
// CCDIV_ROUND_EN adds one extra quotient bit and rounds the magnitude half away from zero.
package ccdiv_pkg;

    localparam int TOTAL_WIDTH = 8;
    localparam int FRAC_WIDTH  = 4;

    // Width of Nr, Ni and D, and of the unrounded quotient.
    localparam int NW = 2 * TOTAL_WIDTH + 1;
    localparam int QW = NW + FRAC_WIDTH;

`ifdef CCDIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    // Bits actually produced by the divider; one extra when rounding.
    localparam int QWD = QW + RND;
    localparam int CW  = $clog2(QWD);

    typedef struct packed {
        logic signed [TOTAL_WIDTH-1:0] q;
        logic                          sat;
    } qres_t;

    function automatic logic [NW-1:0] mag(input logic signed [NW-1:0] v);
        return v[NW-1] ? unsigned'(-v) : unsigned'(v);
    endfunction

    // Round (optionally), restore the sign and clamp to the signed output range.
    function automatic qres_t finalize(input logic [QWD-1:0] q, input logic neg);
        logic [QWD:0] m;
        qres_t        r;
`ifdef CCDIV_ROUND_EN
        m = ({1'b0, q} + {{QWD{1'b0}}, 1'b1}) >> 1;
`else
        m = {1'b0, q};
`endif
        r.sat = 1'b0;
        if (!neg) begin
            if (|m[QWD:TOTAL_WIDTH-1]) begin
                r.q   = {1'b0, {(TOTAL_WIDTH-1){1'b1}}};
                r.sat = 1'b1;
            end else begin
                r.q = m[TOTAL_WIDTH-1:0];
            end
        end else begin
            if (|m[QWD:TOTAL_WIDTH] || (m[TOTAL_WIDTH-1] && |m[TOTAL_WIDTH-2:0])) begin
                r.q   = {1'b1, {(TOTAL_WIDTH-1){1'b0}}};
                r.sat = 1'b1;
            end else begin
                r.q = -m[TOTAL_WIDTH-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ccdiv_udiv.sv
// Iterative unsigned restoring divider: one quotient bit per step, MSB first.
// The quotient register doubles as the dividend shift register.
module ccdiv_udiv #(
    parameter int NW = 21,
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic [NW-1:0] quotient
);

    logic [DW-1:0] rem_q;
    logic [NW-1:0] quo_q;
    logic [DW:0]   shifted;
    logic [DW:0]   diff;
    logic          ge;

    assign shifted  = {rem_q, quo_q[NW-1]};
    assign ge       = shifted >= {1'b0, divisor};
    assign diff     = shifted - {1'b0, divisor};
    assign quotient = quo_q;

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
        end else if (step) begin
            // The partial remainder is always below the divisor, so DW bits suffice.
            rem_q <= ge ? diff[DW-1:0] : shifted[DW-1:0];
            quo_q <= {quo_q[NW-2:0], ge};
        end
    end

endmodule

// File: rtl/ccdiv.sv
// Complex fixed-point divider (ar+j*ai)/(br+j*bi) in S3.4, two parallel restoring dividers.
// Optional macro CCDIV_ROUND_EN: round half away from zero instead of truncating.
module ccdiv
    import ccdiv_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic signed [TOTAL_WIDTH-1:0] ar,
    input  logic signed [TOTAL_WIDTH-1:0] ai,
    input  logic signed [TOTAL_WIDTH-1:0] br,
    input  logic signed [TOTAL_WIDTH-1:0] bi,
    output logic                          busy,
    output logic                          done,
    output logic signed [TOTAL_WIDTH-1:0] qr,
    output logic signed [TOTAL_WIDTH-1:0] qi,
    output logic                          div_by_zero,
    output logic                          sat
);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

    state_t state, state_nxt;
    logic   capture, load, step, finish;

    logic signed [TOTAL_WIDTH-1:0] ar_q, ai_q, br_q, bi_q;
    logic signed [NW-1:0]          nr_c, ni_c, d_c;
    logic signed [NW-1:0]          nr_q, ni_q;
    logic        [NW-1:0]          d_q;
    logic                          dbz_q;
    logic        [CW-1:0]          cnt;
    logic        [QWD-1:0]         q_r, q_i;
    qres_t                         res_r, res_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: a default assignment up front keeps this combinational block latch-free.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = (d_c == '0) ? DONE : DIV;
            DIV:  if (cnt == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        capture = (state == IDLE) && start;
        load    = (state == LOAD);
        step    = (state == DIV);
        finish  = (state == DONE);
        busy    = (state != IDLE);
    end

    assign nr_c = NW'(ar_q) * NW'(br_q) + NW'(ai_q) * NW'(bi_q);
    assign ni_c = NW'(ai_q) * NW'(br_q) - NW'(ar_q) * NW'(bi_q);
    assign d_c  = NW'(br_q) * NW'(br_q) + NW'(bi_q) * NW'(bi_q);

    assign res_r = finalize(q_r, nr_q[NW-1]);
    assign res_i = finalize(q_i, ni_q[NW-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_q        <= '0;
            ai_q        <= '0;
            br_q        <= '0;
            bi_q        <= '0;
            nr_q        <= '0;
            ni_q        <= '0;
            d_q         <= '0;
            dbz_q       <= 1'b0;
            cnt         <= '0;
            done        <= 1'b0;
            qr          <= '0;
            qi          <= '0;
            div_by_zero <= 1'b0;
            sat         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (capture) begin
                ar_q <= ar;
                ai_q <= ai;
                br_q <= br;
                bi_q <= bi;
            end
            if (load) begin
                nr_q  <= nr_c;
                ni_q  <= ni_c;
                d_q   <= d_c;
                dbz_q <= (d_c == '0);
                cnt   <= CW'(QWD - 1);
            end else if (step) begin
                cnt <= cnt - 1'b1;
            end
            if (finish) begin
                done        <= 1'b1;
                div_by_zero <= dbz_q;
                qr          <= dbz_q ? '0 : res_r.q;
                qi          <= dbz_q ? '0 : res_i.q;
                sat         <= dbz_q ? 1'b0 : (res_r.sat | res_i.sat);
            end
        end
    end

    // Both dividers load straight from the LOAD-cycle products and share the registered D.
    ccdiv_udiv #(.NW(QWD), .DW(NW)) u_div_r (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .dividend ({mag(nr_c), {(FRAC_WIDTH + RND){1'b0}}}),
        .divisor  (d_q),
        .quotient (q_r)
    );

    ccdiv_udiv #(.NW(QWD), .DW(NW)) u_div_i (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .dividend ({mag(ni_c), {(FRAC_WIDTH + RND){1'b0}}}),
        .divisor  (d_q),
        .quotient (q_i)
    );

endmodule

// File: tb/tb_ccdiv.sv
// Scoreboard bench for ccdiv: directed vectors push expectations, a monitor checks each done.
// Expected values track CCDIV_ROUND_EN when it is defined for the build.
module tb_ccdiv;

`ifdef CCDIV_ROUND_EN
    localparam int LAT   = 24;
    localparam int Q_POS = 3;
`else
    localparam int LAT   = 23;
    localparam int Q_POS = 2;
`endif

    typedef struct {
        string name;
        int    qr;
        int    qi;
        int    dbz;
        int    sat;
        int    lat;
        int    start_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic signed [7:0] ar = '0, ai = '0, br = '0, bi = '0;
    logic             busy, done, div_by_zero, sat;
    logic signed [7:0] qr, qi;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    ccdiv dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ar          (ar),
        .ai          (ai),
        .br          (br),
        .bi          (bi),
        .busy        (busy),
        .done        (done),
        .qr          (qr),
        .qi          (qi),
        .div_by_zero (div_by_zero),
        .sat         (sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_qr"},  int'(qr), e.qr);
                check({e.name, "_qi"},  int'(qi), e.qi);
                check({e.name, "_dbz"}, int'(div_by_zero), e.dbz);
                check({e.name, "_sat"}, int'(sat), e.sat);
                check({e.name, "_lat"}, cyc - e.start_cyc, e.lat);
            end
        end
    end

    // Called just after a negedge; start is sampled at the following posedge.
    task automatic issue(input string name, input int a_r, input int a_i, input int b_r,
                         input int b_i, input int eqr, input int eqi, input int edbz,
                         input int esat, input int elat);
        exp_t e;
        ar    = 8'(a_r);
        ai    = 8'(a_i);
        br    = 8'(b_r);
        bi    = 8'(b_i);
        start = 1'b1;
        e = '{name, eqr, eqi, edbz, esat, elat, cyc + 1};
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        ar    = 8'sh5a;
        ai    = -8'sd77;
        br    = 8'sh13;
        bi    = 8'sh00;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", int'(done), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("queue_drain", sb.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_qr",   int'(qr), 0);
        check("rst_qi",   int'(qi), 0);
        check("rst_dbz",  int'(div_by_zero), 0);
        check("rst_sat",  int'(sat), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal divide, then a back-to-back start in the done cycle.
        issue("basic", 40, 44, 32, 8, 24, 16, 0, 0, LAT);
        wait_done();
        issue("sat_pos", 127, 0, 1, 0, 127, 0, 0, 1, LAT);
        wait_idle();

        issue("dbz", 50, -3, 0, 0, 0, 0, 1, 0, 2);
        wait_idle();
        issue("round_pos", 16, 0, 96, 0, Q_POS, 0, 0, 0, LAT);
        wait_idle();
        issue("round_neg", -16, 0, 96, 0, -Q_POS, 0, 0, 0, LAT);
        wait_idle();
        issue("sat_neg", -128, 0, 1, 0, -128, 0, 0, 1, LAT);
        wait_idle();
        issue("inv_j", 16, 0, 0, 16, 0, -16, 0, 0, LAT);
        wait_idle();

        // Start pulsed mid-operation must be ignored.
        issue("ignore", 40, 44, 32, 8, 24, 16, 0, 0, LAT);
        repeat (4) @(negedge clk);
        ar    = 8'sd100;
        br    = 8'sd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (30) @(negedge clk);

        // Reset mid-operation abandons it with no done.
        issue("aborted", 127, 0, 1, 0, 127, 0, 0, 1, LAT);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_qr",   int'(qr), 0);
        check("abort_sat",  int'(sat), 0);
        check("abort_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        issue("unity", 1, 1, 1, 1, 16, 0, 0, 0, LAT);
        wait_idle();
        repeat (5) @(negedge clk);
        check("hold_qr",   int'(qr), 16);
        check("hold_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
